ikbd_serial_peer: RTL and testbench
===================================

Name: ikbd_serial_peer

Overview:
- Device-side 8N1 serial endpoint on the keyboard/MIDI link, used to model the IKBD (HD6301) end of the ACIA link.
- Receives command bytes from the ACIA `tx` line and hands each one to the io controller as a single-cycle strobe.
- Sends io-controller-supplied bytes (key scancodes, mouse packets) back to the ACIA `rx` line from a small transmit FIFO.
- Default timing is 7812.5 bps from a 32 MHz clock with 16x oversampling.

Parameters:
- CLK_DIV, 256, system clocks per oversample tick (32 MHz / 256 = 16 x 7812.5 Hz); use 64 for 31250 bps MIDI.
- TX_DEPTH, 4, transmit FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  serial input, driven by the ACIA tx line; asynchronous, idles high.
- tx  out  1  serial output, driving the ACIA rx line; idles high.
- tx_data  in  8  byte to transmit.
- tx_strobe  in  1  one-cycle push of tx_data into the FIFO.
- tx_full  out  1  FIFO holds TX_DEPTH entries.
- tx_busy  out  1  a frame is being shifted out, or the FIFO is non-empty.
- rx_data  out  8  last correctly framed received byte.
- rx_strobe  out  1  one-cycle pulse when rx_data updates.
- rx_frame_error  out  1  last frame had a low stop bit.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - tx=1, tx_full=0, tx_busy=0.
  - rx_data=0x00, rx_strobe=0, rx_frame_error=0.
  - FIFO empty; both FSMs in IDLE; tick counter=0; rx synchroniser flops=1.
- Reset asserted mid-frame: tx returns high on the next clock and queued bytes are discarded.
- Tick: free-running counter 0..CLK_DIV-1; tick=1 for one clock when counter==CLK_DIV-1. Both FSMs advance only on tick.
- rx synchroniser: two flops; the FSM uses the second flop (rs).
- RX FSM (states IDLE, START, DATA, STOP, BREAK; sub-bit counter sc 4 bits; bit counter bc 3 bits):
  - IDLE: rs=0 at a tick -> START, sc=0.
  - START: sc increments each tick.
    - At sc==7: rs=0 -> DATA with sc=0, bc=0.
    - At sc==7: rs=1 -> IDLE (glitch rejected).
  - DATA: at sc==15, shift rs into a shift register LSB-first (new bit enters bit 7, register shifts right). After bc==7 -> STOP, otherwise bc++.
  - STOP: at sc==15:
    - rs=1: rx_data <= shift register, rx_strobe=1 for exactly one clock, rx_frame_error <= 0, -> IDLE.
    - rs=0: rx_frame_error <= 1, no strobe, -> BREAK.
  - BREAK: wait for rs=1 at a tick -> IDLE. A held-low line (break) yields exactly one frame error, not repeated frames.
  - Every bit is sampled at mid-bit, 8 ticks after the detected falling edge plus n*16 ticks.
- TX FSM (IDLE, START, DATA, STOP):
  - Each bit lasts exactly 16 ticks = 16*CLK_DIV clocks.
  - IDLE: tx=1. When the FIFO is non-empty and a tick occurs: pop the head into a shift register -> START.
  - START: tx=0.
  - DATA: tx=shift[0], shifting right after each bit; 8 bits.
  - STOP: tx=1 for 16 ticks. At the end: FIFO non-empty -> pop and -> START on that same tick (back-to-back, no idle gap); otherwise -> IDLE.
- FIFO:
  - Write accepted when count<TX_DEPTH, or when count==TX_DEPTH and a pop occurs in the same clock.
  - A write otherwise is silently dropped.
  - tx_full=(count==TX_DEPTH), registered from the post-update count. tx_busy=(state!=IDLE)||(count!=0).
  - Pointers wrap modulo TX_DEPTH; count is log2(TX_DEPTH)+1 bits.
- Frame length: 10 bits = 160 ticks = 40960 clocks at the defaults.
- Simultaneous activity: RX and TX are fully independent (full duplex) and share only the tick.

Decomposition:
- Package ikbd_serial_pkg:
  - Default constants CLK_DIV_IKBD=256 and CLK_DIV_MIDI=64.
  - Constants OVERSAMPLE=16 and FRAME_BITS=10.
  - RX state enum (IDLE, START, DATA, STOP, BREAK) and TX state enum (IDLE, START, DATA, STOP).
- One sub-module, ikbd_tx_fifo: synchronous FIFO with push, pop, dout, count, full and empty.
- Tick generator and both FSMs stay in the top module.

Test Plan:
- Push tx_data=0x80 once -> tx goes low at the next tick. Then 0 for 16 ticks, bits 0,0,0,0,0,0,0,1, then high for 16 ticks; frame is 40960 clocks; tx_busy drops at frame end.
- Push 0xF1, 0x02, 0x03, 0x04, 0x05 in 5 consecutive clocks with TX_DEPTH=4 -> first four accepted, 0x05 dropped, tx_full=1 after the fourth push. Four frames are sent back-to-back with no gap between a stop bit and the next start bit.
- Drive rx with frame 0xA5 at exactly 7812.5 bps -> rx_strobe pulses once, about 8 ticks before the nominal frame end; rx_data=0xA5; rx_frame_error=0.
- Drive rx low for 3 ticks then high -> start bit rejected, no strobe, FSM back in IDLE.
- Drive rx with frame 0x3C and the stop bit low, holding rx low for 500 ticks -> exactly one rx_frame_error=1, no strobe, rx_data unchanged. Then send a valid 0x12 -> strobe, rx_data=0x12, rx_frame_error=0.
- Assert reset for one clock during the DATA phase of a TX frame with 2 bytes queued -> tx=1 on the next clock, tx_busy=0, no further frames sent.

Source files
------------

// File: rtl/ikbd_serial_pkg.sv
// Shared constants and state encodings for the IKBD-side 8N1 serial peer.
package ikbd_serial_pkg;

  localparam int CLK_DIV_IKBD = 256;
  localparam int CLK_DIV_MIDI = 64;
  localparam int OVERSAMPLE   = 16;
  localparam int FRAME_BITS   = 10;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/ikbd_tx_fifo.sv
// Small synchronous FIFO feeding the serial transmitter; a push into a full
// FIFO is only accepted when a pop frees a slot in the same clock.
module ikbd_tx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [AW:0]       count_nxt;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < FULL_CNT) || do_pop);
  assign dout    = mem[rd_ptr];
  assign empty   = (count == '0);

  always_comb begin
    count_nxt = count + {AW'(0), do_push} - {AW'(0), do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ikbd_serial_peer.sv
// Device-side 8N1 endpoint of the IKBD/ACIA link: 16x oversampled receiver
// with break handling, and a FIFO-fed transmitter sending frames back to back.
module ikbd_serial_peer
  import ikbd_serial_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_IKBD,
  parameter int TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe,
  output logic       tx_full,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       rx_frame_error
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
  localparam logic [3:0]    SC_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    SC_MID    = 4'(OVERSAMPLE / 2 - 1);

  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= tick ? '0 : div_cnt + CW'(1);
  end

  // Receive path: two-flop synchroniser, then the mid-bit sampling FSM
  logic      rs_meta;
  logic      rs;
  rx_state_t rx_state;
  logic [3:0] rx_sc;
  logic [2:0] rx_bc;
  logic [7:0] rx_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rs_meta <= rx;
      rs      <= rs_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state       <= RX_IDLE;
      rx_sc          <= '0;
      rx_bc          <= '0;
      rx_data        <= '0;
      rx_strobe      <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      if (tick) begin
        case (rx_state)
          RX_IDLE: begin
            if (!rs) begin
              rx_state <= RX_START;
              rx_sc    <= '0;
            end
          end
          RX_START: begin
            if (rx_sc == SC_MID) begin
              rx_sc    <= '0;
              rx_bc    <= '0;
              rx_state <= rs ? RX_IDLE : RX_DATA;
            end else begin
              rx_sc <= rx_sc + 4'd1;
            end
          end
          RX_DATA: begin
            rx_sc <= rx_sc + 4'd1;
            if (rx_sc == SC_LAST) begin
              if (rx_bc == 3'd7) rx_state <= RX_STOP;
              else               rx_bc    <= rx_bc + 3'd1;
            end
          end
          RX_STOP: begin
            rx_sc <= rx_sc + 4'd1;
            if (rx_sc == SC_LAST) begin
              if (rs) begin
                rx_data        <= rx_shift;
                rx_strobe      <= 1'b1;
                rx_frame_error <= 1'b0;
                rx_state       <= RX_IDLE;
              end else begin
                rx_frame_error <= 1'b1;
                rx_state       <= RX_BREAK;
              end
            end
          end
          RX_BREAK: begin
            // A held-low line must return high before a new start bit counts.
            if (rs) rx_state <= RX_IDLE;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tick && rx_state == RX_DATA && rx_sc == SC_LAST)
      rx_shift <= {rs, rx_shift[7:1]};
  end

  // Transmit path: FIFO plus frame FSM
  tx_state_t  tx_state;
  logic [3:0] tx_sc;
  logic [2:0] tx_bc;
  logic [7:0] tx_shift;
  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic [PW:0] fifo_count;
  logic       fifo_empty;

  assign fifo_pop = tick && !fifo_empty &&
                    ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_sc == SC_LAST));
  assign tx_busy  = (tx_state != TX_IDLE) || (fifo_count != '0);

  ikbd_tx_fifo #(
    .DEPTH  (TX_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_strobe),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (tx_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_sc    <= '0;
      tx_bc    <= '0;
      tx       <= 1'b1;
    end else if (tick) begin
      case (tx_state)
        TX_IDLE: begin
          if (fifo_pop) begin
            tx_state <= TX_START;
            tx_sc    <= '0;
            tx       <= 1'b0;
          end
        end
        TX_START: begin
          tx_sc <= tx_sc + 4'd1;
          if (tx_sc == SC_LAST) begin
            tx_state <= TX_DATA;
            tx_bc    <= '0;
            tx       <= tx_shift[0];
          end
        end
        TX_DATA: begin
          tx_sc <= tx_sc + 4'd1;
          if (tx_sc == SC_LAST) begin
            if (tx_bc == 3'd7) begin
              tx_state <= TX_STOP;
              tx       <= 1'b1;
            end else begin
              tx_bc <= tx_bc + 3'd1;
              tx    <= tx_shift[1];
            end
          end
        end
        TX_STOP: begin
          tx_sc <= tx_sc + 4'd1;
          if (tx_sc == SC_LAST) begin
            // Next queued byte starts on the same tick: no idle gap.
            if (fifo_pop) begin
              tx_state <= TX_START;
              tx       <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_pop)
      tx_shift <= fifo_dout;
    else if (tick && tx_state == TX_DATA && tx_sc == SC_LAST)
      tx_shift <= {1'b0, tx_shift[7:1]};
  end

endmodule

// File: tb/tb_ikbd_serial_peer.sv
// Self-checking bench for ikbd_serial_peer with a shortened tick divider.
module tb_ikbd_serial_peer;
  import ikbd_serial_pkg::*;

  localparam int DIV   = 16;
  localparam int BIT   = OVERSAMPLE * DIV;
  localparam int FRAME = FRAME_BITS * BIT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       tx;
  logic [7:0] tx_data = 8'h00;
  logic       tx_strobe = 1'b0;
  logic       tx_full;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       rx_frame_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  ikbd_serial_peer #(.CLK_DIV(DIV), .TX_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx             (rx),
    .tx             (tx),
    .tx_data        (tx_data),
    .tx_strobe      (tx_strobe),
    .tx_full        (tx_full),
    .tx_busy        (tx_busy),
    .rx_data        (rx_data),
    .rx_strobe      (rx_strobe),
    .rx_frame_error (rx_frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      strobe_cyc = cyc;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: cycle %0d reached, required finish before 95000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic push_byte(input logic [7:0] d);
    tx_data   = d;
    tx_strobe = 1'b1;
    @(negedge clk);
    tx_strobe = 1'b0;
  endtask

  // Decodes one frame from tx by sampling each bit at its middle.
  task automatic uart_capture(input int timeout, output logic [7:0] b,
                              output logic stop_bit, output logic found, output int c0);
    b = 8'h00; stop_bit = 1'b0; found = 1'b0; c0 = 0;
    for (int i = 0; i < timeout; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) return;
    c0 = cyc;
    repeat (BIT / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      b[i] = tx;
    end
    repeat (BIT) @(negedge clk);
    stop_bit = tx;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input int hold_low);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (stop) begin
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (hold_low) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b expected 0", tx_full); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_strobe !== 1'b0) begin errors++; $display("FAIL reset_rx_strobe: got %b expected 0", rx_strobe); end
    checks++; if (rx_frame_error !== 1'b0) begin errors++; $display("FAIL reset_rx_frame_error: got %b expected 0", rx_frame_error); end
  endtask

  task automatic test_tx_single();
    int p, c0;
    logic [7:0] b, e;
    logic sb, found;
    p = cyc;
    tx_q.push_back(8'h80);
    push_byte(8'h80);
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_push: got %b expected 1", tx_busy); end
    uart_capture(4 * DIV, b, sb, found, c0);
    e = tx_q.pop_front();
    checks++;
    if (!found) begin
      errors++; $display("FAIL single_start: no start bit within %0d clocks", 4 * DIV);
      return;
    end
    checks++; if (c0 - p > DIV + 2) begin errors++; $display("FAIL single_start_latency: got %0d clocks expected <= %0d", c0 - p, DIV + 2); end
    checks++; if (b !== e) begin errors++; $display("FAIL single_data: got %h expected %h", b, e); end
    checks++; if (sb !== 1'b1) begin errors++; $display("FAIL single_stop: got %b expected 1", sb); end
    repeat (BIT / 2 - 1) @(negedge clk);
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_before_end: got %b expected 1 at %0d clocks", tx_busy, cyc - c0); end
    @(negedge clk);
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_end: got %b expected 0 at %0d clocks", tx_busy, cyc - c0); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_idle_line: got %b expected 1", tx); end
  endtask

  // Starts right after a tick, so all five pushes land before the first pop.
  task automatic test_tx_fifo_full();
    logic [7:0] vals [5];
    logic [7:0] b, e;
    logic sb, found;
    int c0, prev;
    vals = '{8'hF1, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) tx_q.push_back(vals[i]);
      tx_data   = vals[i];
      tx_strobe = 1'b1;
      @(negedge clk);
      if (i == 3) begin
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL full_after_4: got %b expected 1", tx_full); end
      end
    end
    tx_strobe = 1'b0;
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL full_after_5: got %b expected 1", tx_full); end
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      uart_capture((k == 0) ? 4 * DIV : BIT, b, sb, found, c0);
      e = tx_q.pop_front();
      checks++;
      if (!found) begin
        errors++; $display("FAIL b2b_frame%0d: no start bit, expected data %h", k, e);
        return;
      end
      checks++; if (b !== e) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, b, e); end
      checks++; if (sb !== 1'b1) begin errors++; $display("FAIL b2b_stop%0d: got %b expected 1", k, sb); end
      if (k > 0) begin
        checks++; if (c0 - prev != FRAME) begin errors++; $display("FAIL b2b_spacing%0d: got %0d clocks expected %0d", k, c0 - prev, FRAME); end
      end
      prev = c0;
    end
    uart_capture(2 * BIT, b, sb, found, c0);
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL dropped_byte_sent: got frame %h expected none", b); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b expected 0", tx_busy); end
  endtask

  task automatic test_rx_good();
    int s0, st, dt;
    logic [7:0] e;
    s0 = strobe_cnt;
    st = cyc;
    rx_q.push_back(8'hA5);
    send_rx(8'hA5, 1'b1, 0);
    repeat (BIT) @(negedge clk);
    e = rx_q.pop_front();
    dt = strobe_cyc - st;
    checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL rx_good_strobes: got %0d expected 1", strobe_cnt - s0); end
    checks++; if (rx_data !== e) begin errors++; $display("FAIL rx_good_data: got %h expected %h", rx_data, e); end
    checks++; if (rx_frame_error !== 1'b0) begin errors++; $display("FAIL rx_good_ferr: got %b expected 0", rx_frame_error); end
    checks++;
    if (dt < 152 * DIV || dt > 153 * DIV + 4) begin
      errors++; $display("FAIL rx_good_strobe_time: got %0d clocks expected %0d..%0d", dt, 152 * DIV, 153 * DIV + 4);
    end
  endtask

  task automatic test_rx_glitch();
    int s0;
    s0 = strobe_cnt;
    rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checks++; if (strobe_cnt - s0 != 0) begin errors++; $display("FAIL glitch_strobes: got %0d expected 0", strobe_cnt - s0); end
    checks++; if (rx_frame_error !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b expected 0", rx_frame_error); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %h expected a5", rx_data); end
  endtask

  task automatic test_rx_break();
    int s0;
    logic [7:0] e;
    s0 = strobe_cnt;
    send_rx(8'h3C, 1'b0, 500 * DIV);
    repeat (2 * BIT) @(negedge clk);
    checks++; if (rx_frame_error !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b expected 1", rx_frame_error); end
    checks++; if (strobe_cnt - s0 != 0) begin errors++; $display("FAIL break_strobes: got %0d expected 0", strobe_cnt - s0); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL break_data: got %h expected a5", rx_data); end
    s0 = strobe_cnt;
    rx_q.push_back(8'h12);
    send_rx(8'h12, 1'b1, 0);
    repeat (BIT) @(negedge clk);
    e = rx_q.pop_front();
    checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL after_break_strobes: got %0d expected 1", strobe_cnt - s0); end
    checks++; if (rx_data !== e) begin errors++; $display("FAIL after_break_data: got %h expected %h", rx_data, e); end
    checks++; if (rx_frame_error !== 1'b0) begin errors++; $display("FAIL after_break_ferr: got %b expected 0", rx_frame_error); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    logic sb, found;
    int c0;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    found = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL midreset_start: got no start bit expected one"); end
    repeat (4 * BIT) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b expected 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", tx_busy); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL midreset_full: got %b expected 0", tx_full); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midreset_rx_data: got %h expected 00", rx_data); end
    uart_capture(2 * FRAME, b, sb, found, c0);
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL midreset_more_frames: got frame %h expected none", b); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy_late: got %b expected 0", tx_busy); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_fifo_full();
    test_rx_good();
    test_rx_glitch();
    test_rx_break();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
